// File: rtl/iob_ibex_obi2axi.sv
// OBI-to-AXI4 bridge for an Ibex core port: single-beat reads/writes, in-order
// responses tracked by a tag FIFO, and responses returned to OBI with 0-cycle latency.
module iob_ibex_obi2axi #(
  parameter int AXI_ID_W   = 1,
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_DATA_W = 32,
  parameter int AXI_LEN_W  = 8,
  parameter int MAX_OUTST  = 4,
  parameter int WRITE_EN   = 1,
  parameter int INSTR      = 0,
  parameter int AXI_ID     = 0
) (
  input  logic                    clk_i,
  input  logic                    cke_i,
  input  logic                    rst_i,
  input  logic                    obi_req_i,
  output logic                    obi_gnt_o,
  input  logic [AXI_ADDR_W-1:0]   obi_addr_i,
  input  logic                    obi_we_i,
  input  logic [AXI_DATA_W/8-1:0] obi_be_i,
  input  logic [AXI_DATA_W-1:0]   obi_wdata_i,
  output logic                    obi_rvalid_o,
  output logic [AXI_DATA_W-1:0]   obi_rdata_o,
  output logic                    obi_err_o,
  output logic                    arvalid_o,
  input  logic                    arready_i,
  output logic [AXI_ADDR_W-1:0]   araddr_o,
  output logic [2:0]              arprot_o,
  output logic [AXI_ID_W-1:0]     arid_o,
  output logic [AXI_LEN_W-1:0]    arlen_o,
  output logic [2:0]              arsize_o,
  output logic [1:0]              arburst_o,
  output logic                    arlock_o,
  output logic [3:0]              arcache_o,
  output logic [3:0]              arqos_o,
  input  logic                    rvalid_i,
  output logic                    rready_o,
  input  logic [AXI_DATA_W-1:0]   rdata_i,
  input  logic [1:0]              rresp_i,
  input  logic [AXI_ID_W-1:0]     rid_i,
  input  logic                    rlast_i,
  output logic                    awvalid_o,
  input  logic                    awready_i,
  output logic [AXI_ADDR_W-1:0]   awaddr_o,
  output logic [2:0]              awprot_o,
  output logic [AXI_ID_W-1:0]     awid_o,
  output logic [AXI_LEN_W-1:0]    awlen_o,
  output logic [2:0]              awsize_o,
  output logic [1:0]              awburst_o,
  output logic                    awlock_o,
  output logic [3:0]              awcache_o,
  output logic [3:0]              awqos_o,
  output logic                    wvalid_o,
  input  logic                    wready_i,
  output logic [AXI_DATA_W-1:0]   wdata_o,
  output logic [AXI_DATA_W/8-1:0] wstrb_o,
  output logic                    wlast_o,
  input  logic                    bvalid_i,
  output logic                    bready_o,
  input  logic [1:0]              bresp_i,
  input  logic [AXI_ID_W-1:0]     bid_i
);

  localparam int OFF_W = $clog2(AXI_DATA_W / 8);
  localparam int PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int CNT_W = $clog2(MAX_OUTST + 1);
  localparam bit WE    = (WRITE_EN != 0);
  localparam logic [PTR_W-1:0]      PTR_LAST  = PTR_W'(MAX_OUTST - 1);
  localparam logic [CNT_W-1:0]      CNT_FULL  = CNT_W'(MAX_OUTST);
  localparam logic [AXI_ADDR_W-1:0] ADDR_MASK = ~AXI_ADDR_W'((1 << OFF_W) - 1);

  logic [MAX_OUTST-1:0] tag_q, tag_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 aw_done_q, aw_done_d, w_done_q, w_done_d;

  logic act, full, empty, head;
  logic req_rd, req_wr, aw_fire, w_fire, rd_gnt, wr_gnt, r_fire, b_fire;
  logic unused_in;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    ptr_next = (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // Fixed single-beat AXI attributes
  assign arlen_o   = '0;
  assign arsize_o  = 3'(OFF_W);
  assign arburst_o = 2'b01;
  assign arlock_o  = 1'b0;
  assign arcache_o = 4'b0011;
  assign arqos_o   = 4'b0000;
  assign arprot_o  = {(INSTR != 0), 2'b00};
  assign arid_o    = AXI_ID_W'(AXI_ID);
  assign araddr_o  = obi_addr_i & ADDR_MASK;
  assign awlen_o   = '0;
  assign awsize_o  = 3'(OFF_W);
  assign awburst_o = 2'b01;
  assign awlock_o  = 1'b0;
  assign awcache_o = 4'b0011;
  assign awqos_o   = 4'b0000;
  assign awprot_o  = {(INSTR != 0), 2'b00};
  assign awid_o    = AXI_ID_W'(AXI_ID);
  assign awaddr_o  = obi_addr_i & ADDR_MASK;
  assign wdata_o   = obi_wdata_i;
  assign wstrb_o   = obi_be_i;
  assign wlast_o   = 1'b1;

  // Reset overrides the clock enable
  assign act    = cke_i & ~rst_i;
  assign full   = (cnt_q == CNT_FULL);
  assign empty  = (cnt_q == '0);
  assign head   = tag_q[rd_ptr_q];
  assign req_rd = obi_req_i & ~obi_we_i & ~full & act;
  assign req_wr = obi_req_i & obi_we_i & ~full & act;

  assign arvalid_o = req_rd;
  assign awvalid_o = WE ? (req_wr & ~aw_done_q) : 1'b0;
  assign wvalid_o  = WE ? (req_wr & ~w_done_q) : 1'b0;
  assign aw_fire   = awvalid_o & awready_i;
  assign w_fire    = wvalid_o & wready_i;
  assign rd_gnt    = req_rd & arready_i;
  // Without a write path, writes are granted at once and answered with an error
  assign wr_gnt    = WE ? (req_wr & (aw_done_q | aw_fire) & (w_done_q | w_fire)) : req_wr;
  assign obi_gnt_o = rd_gnt | wr_gnt;

  assign rready_o = ~empty & ~head & act;
  assign bready_o = WE ? (~empty & head & act) : 1'b0;
  assign r_fire   = rvalid_i & rready_o;
  assign b_fire   = WE ? (bvalid_i & bready_o) : (~empty & head & act);

  assign obi_rvalid_o = r_fire | b_fire;
  assign obi_rdata_o  = r_fire ? rdata_i : '0;
  assign obi_err_o    = r_fire ? rresp_i[1] : (b_fire & (WE ? bresp_i[1] : 1'b1));

  assign unused_in = ^{rid_i, rlast_i, bid_i, rresp_i[0], bresp_i[0]};

  always_comb begin
    tag_d     = tag_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    aw_done_d = aw_done_q | aw_fire;
    w_done_d  = w_done_q | w_fire;
    if (obi_gnt_o) begin
      tag_d[wr_ptr_q] = wr_gnt;
      wr_ptr_d        = ptr_next(wr_ptr_q);
      aw_done_d       = 1'b0;
      w_done_d        = 1'b0;
    end
    if (obi_rvalid_o) rd_ptr_d = ptr_next(rd_ptr_q);
    case ({obi_gnt_o, obi_rvalid_o})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  // Tag storage is only meaningful below the count, so it needs no reset
  always_ff @(posedge clk_i) begin
    tag_q <= tag_d;
  end

endmodule

// File: tb/tb_iob_ibex_obi2axi.sv
// Bench for iob_ibex_obi2axi: vector table, directed multi-cycle sequences and a
// randomized run checked against a queue-based model of grant/response ordering.
module tb_iob_ibex_obi2axi;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        cke, rst, obi_req, obi_we, d2_req;
  logic [31:0] obi_addr, obi_wdata;
  logic [3:0]  obi_be;
  logic        arready, awready, wready, rvalid_i, bvalid_i;
  logic [31:0] rdata_i;
  logic [1:0]  rresp_i, bresp_i;
  logic [0:0]  rid_i, bid_i;
  logic        rlast_i;

  logic        gnt, obi_rvalid, obi_err, arvalid, rready, awvalid, wvalid, wlast, bready, arlock, awlock;
  logic [31:0] obi_rdata, araddr, awaddr, wdata;
  logic [3:0]  wstrb, arcache, arqos, awcache, awqos;
  logic [2:0]  arprot, arsize, awprot, awsize;
  logic [1:0]  arburst, awburst;
  logic [7:0]  arlen, awlen;
  logic [0:0]  arid, awid;

  logic        d2_gnt, d2_rvalid, d2_err, d2_arvalid, d2_rready, d2_awvalid, d2_wvalid, d2_wlast, d2_bready;
  logic        d2_arlock, d2_awlock;
  logic [31:0] d2_rdata, d2_araddr, d2_awaddr, d2_wdata;
  logic [3:0]  d2_wstrb, d2_arcache, d2_arqos, d2_awcache, d2_awqos;
  logic [2:0]  d2_arprot, d2_arsize, d2_awprot, d2_awsize;
  logic [1:0]  d2_arburst, d2_awburst;
  logic [7:0]  d2_arlen, d2_awlen;
  logic [0:0]  d2_arid, d2_awid;

  iob_ibex_obi2axi dut (
    .clk_i(clk), .cke_i(cke), .rst_i(rst),
    .obi_req_i(obi_req), .obi_gnt_o(gnt), .obi_addr_i(obi_addr), .obi_we_i(obi_we),
    .obi_be_i(obi_be), .obi_wdata_i(obi_wdata),
    .obi_rvalid_o(obi_rvalid), .obi_rdata_o(obi_rdata), .obi_err_o(obi_err),
    .arvalid_o(arvalid), .arready_i(arready), .araddr_o(araddr), .arprot_o(arprot), .arid_o(arid),
    .arlen_o(arlen), .arsize_o(arsize), .arburst_o(arburst), .arlock_o(arlock), .arcache_o(arcache),
    .arqos_o(arqos),
    .rvalid_i(rvalid_i), .rready_o(rready), .rdata_i(rdata_i), .rresp_i(rresp_i), .rid_i(rid_i),
    .rlast_i(rlast_i),
    .awvalid_o(awvalid), .awready_i(awready), .awaddr_o(awaddr), .awprot_o(awprot), .awid_o(awid),
    .awlen_o(awlen), .awsize_o(awsize), .awburst_o(awburst), .awlock_o(awlock), .awcache_o(awcache),
    .awqos_o(awqos),
    .wvalid_o(wvalid), .wready_i(wready), .wdata_o(wdata), .wstrb_o(wstrb), .wlast_o(wlast),
    .bvalid_i(bvalid_i), .bready_o(bready), .bresp_i(bresp_i), .bid_i(bid_i)
  );

  iob_ibex_obi2axi #(.WRITE_EN(0)) dut_nw (
    .clk_i(clk), .cke_i(cke), .rst_i(rst),
    .obi_req_i(d2_req), .obi_gnt_o(d2_gnt), .obi_addr_i(obi_addr), .obi_we_i(obi_we),
    .obi_be_i(obi_be), .obi_wdata_i(obi_wdata),
    .obi_rvalid_o(d2_rvalid), .obi_rdata_o(d2_rdata), .obi_err_o(d2_err),
    .arvalid_o(d2_arvalid), .arready_i(arready), .araddr_o(d2_araddr), .arprot_o(d2_arprot),
    .arid_o(d2_arid), .arlen_o(d2_arlen), .arsize_o(d2_arsize), .arburst_o(d2_arburst),
    .arlock_o(d2_arlock), .arcache_o(d2_arcache), .arqos_o(d2_arqos),
    .rvalid_i(rvalid_i), .rready_o(d2_rready), .rdata_i(rdata_i), .rresp_i(rresp_i), .rid_i(rid_i),
    .rlast_i(rlast_i),
    .awvalid_o(d2_awvalid), .awready_i(awready), .awaddr_o(d2_awaddr), .awprot_o(d2_awprot),
    .awid_o(d2_awid), .awlen_o(d2_awlen), .awsize_o(d2_awsize), .awburst_o(d2_awburst),
    .awlock_o(d2_awlock), .awcache_o(d2_awcache), .awqos_o(d2_awqos),
    .wvalid_o(d2_wvalid), .wready_i(wready), .wdata_o(d2_wdata), .wstrb_o(d2_wstrb), .wlast_o(d2_wlast),
    .bvalid_i(bvalid_i), .bready_o(d2_bready), .bresp_i(bresp_i), .bid_i(bid_i)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    obi_req = 0; obi_we = 0; d2_req = 0; cke = 1;
    arready = 0; awready = 0; wready = 0; rvalid_i = 0; bvalid_i = 0;
    rdata_i = 0; rresp_i = 0; bresp_i = 0; rid_i = 0; bid_i = 0; rlast_i = 1;
  endtask

  typedef struct {
    logic req; logic we; logic ck; logic [31:0] addr;
    logic [31:0] e_addr; logic e_ar; logic e_aw; logic e_w;
  } vec_t;
  vec_t vecs[6];

  typedef struct { logic wr; logic [31:0] data; logic err; } exp_t;
  typedef struct { logic [31:0] data; logic [1:0] resp; } rsp_t;
  exp_t       exp_q[$];
  rsp_t       r_pend[$];
  logic [1:0] b_pend[$];

  initial begin
    int ngnt;
    logic cur_req, cur_we, aw_seen, w_seen, rv_on, bv_on;
    logic full, e_ar, e_aw, e_w, e_gnt, e_rr, e_br, rf, bf;
    exp_t ex;
    rsp_t rs;
    logic [1:0] br;

    idle(); rst = 1; obi_addr = 0; obi_wdata = 0; obi_be = 0;
    repeat (2) @(negedge clk);
    rst = 0;
    #1;
    chk("rst_gnt", gnt, 0); chk("rst_rvalid", obi_rvalid, 0); chk("rst_err", obi_err, 0);
    chk("rst_rready", rready, 0); chk("rst_bready", bready, 0); chk("rst_arvalid", arvalid, 0);

    chk("const_arsize", arsize, 2); chk("const_awsize", awsize, 2); chk("const_arburst", arburst, 1);
    chk("const_arcache", arcache, 4'b0011); chk("const_arprot", arprot, 0); chk("const_arlen", arlen, 0);
    chk("const_wlast", wlast, 1); chk("const_awid", awid, 0);

    vecs[0] = '{1, 0, 1, 32'h4000_0007, 32'h4000_0004, 1, 0, 0};
    vecs[1] = '{1, 1, 1, 32'h1234_5678, 32'h1234_5678, 0, 1, 1};
    vecs[2] = '{1, 1, 0, 32'h0000_0102, 32'h0000_0100, 0, 0, 0};
    vecs[3] = '{0, 0, 1, 32'h0000_0010, 32'h0000_0010, 0, 0, 0};
    vecs[4] = '{1, 0, 0, 32'h8000_0001, 32'h8000_0000, 0, 0, 0};
    vecs[5] = '{1, 0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 1, 0, 0};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      obi_req = vecs[i].req; obi_we = vecs[i].we; cke = vecs[i].ck; obi_addr = vecs[i].addr;
      #1;
      chk($sformatf("vec%0d_araddr", i), araddr, vecs[i].e_addr);
      chk($sformatf("vec%0d_awaddr", i), awaddr, vecs[i].e_addr);
      chk($sformatf("vec%0d_arvalid", i), arvalid, vecs[i].e_ar);
      chk($sformatf("vec%0d_awvalid", i), awvalid, vecs[i].e_aw);
      chk($sformatf("vec%0d_wvalid", i), wvalid, vecs[i].e_w);
    end
    @(negedge clk); idle();

    // Read with a 3-cycle R latency
    @(negedge clk); obi_req = 1; obi_we = 0; obi_addr = 32'h4000_0004; arready = 1; #1;
    chk("rd_gnt0", gnt, 1); chk("rd_araddr", araddr, 32'h4000_0004); chk("rd_arsize", arsize, 2);
    @(negedge clk); obi_req = 0; arready = 0; #1;
    chk("rd_rready1", rready, 1); chk("rd_rvalid1", obi_rvalid, 0);
    @(negedge clk); #1; chk("rd_rvalid2", obi_rvalid, 0);
    @(negedge clk); rvalid_i = 1; rdata_i = 32'hDEAD_BEEF; rresp_i = 0; #1;
    chk("rd_rvalid3", obi_rvalid, 1); chk("rd_rdata3", obi_rdata, 32'hDEAD_BEEF); chk("rd_err3", obi_err, 0);
    @(negedge clk); rvalid_i = 0; #1; chk("rd_rready4", rready, 0);

    // Split write: W first, AW two cycles later
    @(negedge clk); obi_req = 1; obi_we = 1; obi_be = 4'b0011; obi_wdata = 32'h1234; obi_addr = 32'h100;
    wready = 1; #1;
    chk("sw_wvalid0", wvalid, 1); chk("sw_awvalid0", awvalid, 1); chk("sw_gnt0", gnt, 0);
    chk("sw_wstrb", wstrb, 4'b0011); chk("sw_wdata", wdata, 32'h1234);
    @(negedge clk); wready = 0; #1;
    chk("sw_wvalid1", wvalid, 0); chk("sw_awvalid1", awvalid, 1); chk("sw_gnt1", gnt, 0);
    @(negedge clk); awready = 1; #1;
    chk("sw_awvalid2", awvalid, 1); chk("sw_gnt2", gnt, 1); chk("sw_wvalid2", wvalid, 0);
    @(negedge clk); obi_req = 0; awready = 0; bvalid_i = 1; bresp_i = 2'b10; #1;
    chk("sw_bready", bready, 1); chk("sw_rvalid", obi_rvalid, 1); chk("sw_err", obi_err, 1);
    chk("sw_rdata", obi_rdata, 0);
    @(negedge clk); bvalid_i = 0; bresp_i = 0; #1; chk("sw_bready_after", bready, 0);

    // Read, write, read; B offered before the first R
    @(negedge clk); obi_req = 1; obi_we = 0; obi_addr = 32'h200; arready = 1; awready = 1; wready = 1; #1;
    chk("ord_gnt_r0", gnt, 1);
    @(negedge clk); obi_we = 1; #1; chk("ord_gnt_w", gnt, 1);
    @(negedge clk); obi_we = 0; #1; chk("ord_gnt_r1", gnt, 1);
    @(negedge clk); idle(); bvalid_i = 1; #1;
    chk("ord_bready3", bready, 0); chk("ord_rready3", rready, 1); chk("ord_rvalid3", obi_rvalid, 0);
    @(negedge clk); rvalid_i = 1; rdata_i = 32'h11; #1;
    chk("ord_bready4", bready, 0); chk("ord_rv4", obi_rvalid, 1); chk("ord_rdata4", obi_rdata, 32'h11);
    @(negedge clk); rvalid_i = 0; #1;
    chk("ord_rv5", obi_rvalid, 1); chk("ord_bready5", bready, 1); chk("ord_rdata5", obi_rdata, 0);
    chk("ord_err5", obi_err, 0);
    @(negedge clk); bvalid_i = 0; rvalid_i = 1; rdata_i = 32'h22; #1;
    chk("ord_rv6", obi_rvalid, 1); chk("ord_rdata6", obi_rdata, 32'h22);
    @(negedge clk); idle(); #1; chk("ord_rready7", rready, 0);

    // FIFO full: fifth read waits for a pop, no same-cycle bypass
    ngnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); obi_req = 1; obi_we = 0; arready = 1; #1;
      if (gnt === 1'b1) ngnt++;
      if (i == 4) chk("full_arvalid5", arvalid, 0);
    end
    chk("full_ngrants", ngnt, 4);
    @(negedge clk); rvalid_i = 1; rdata_i = 32'h0; #1;
    chk("full_pop_rv", obi_rvalid, 1); chk("full_pop_gnt", gnt, 0);
    @(negedge clk); rvalid_i = 0; #1; chk("full_gnt_next", gnt, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); obi_req = 0; rvalid_i = 1; rdata_i = 32'h100 + i; #1;
      chk($sformatf("full_drain%0d", i), obi_rdata, 32'h100 + i);
    end
    @(negedge clk); idle(); #1; chk("full_empty", rready, 0);

    // Reset with two reads outstanding
    @(negedge clk); obi_req = 1; obi_we = 0; arready = 1; #1; chk("rr_gnt0", gnt, 1);
    @(negedge clk); #1; chk("rr_gnt1", gnt, 1);
    @(negedge clk); idle(); rst = 1;
    @(negedge clk); rst = 0; #1;
    chk("rr_rready", rready, 0); chk("rr_bready", bready, 0); chk("rr_gnt", gnt, 0);
    chk("rr_rvalid", obi_rvalid, 0); chk("rr_arvalid", arvalid, 0); chk("rr_awvalid", awvalid, 0);
    chk("rr_wvalid", wvalid, 0);
    @(negedge clk); obi_req = 1; arready = 1; #1; chk("rr_new_gnt", gnt, 1);
    @(negedge clk); idle(); rvalid_i = 1; rdata_i = 32'h55; #1;
    chk("rr_new_rv", obi_rvalid, 1); chk("rr_new_rdata", obi_rdata, 32'h55);
    @(negedge clk); idle(); #1; chk("rr_done", rready, 0);

    // Write request on the write-disabled instance
    @(negedge clk); d2_req = 1; obi_we = 1; awready = 1; wready = 1; #1;
    chk("nw_gnt", d2_gnt, 1); chk("nw_awvalid", d2_awvalid, 0); chk("nw_wvalid", d2_wvalid, 0);
    chk("nw_rv0", d2_rvalid, 0);
    @(negedge clk); idle(); #1;
    chk("nw_rv1", d2_rvalid, 1); chk("nw_err1", d2_err, 1); chk("nw_bready", d2_bready, 0);
    @(negedge clk); #1; chk("nw_rv2", d2_rvalid, 0);

    // Randomized traffic against an in-order response queue model
    cur_req = 0; cur_we = 0; aw_seen = 0; w_seen = 0; rv_on = 0; bv_on = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (!cur_req && $urandom_range(0, 1) == 1) begin
        cur_req = 1; cur_we = $urandom_range(0, 1);
        obi_addr = $urandom; obi_be = 4'($urandom); obi_wdata = $urandom;
      end
      obi_req = cur_req; obi_we = cur_we;
      cke = ($urandom_range(0, 7) != 0);
      arready = $urandom_range(0, 1); awready = $urandom_range(0, 1); wready = $urandom_range(0, 1);
      if (!rv_on && r_pend.size() > 0 && $urandom_range(0, 1) == 1) rv_on = 1;
      if (!bv_on && b_pend.size() > 0 && $urandom_range(0, 1) == 1) bv_on = 1;
      rvalid_i = rv_on; bvalid_i = bv_on;
      if (rv_on) begin rdata_i = r_pend[0].data; rresp_i = r_pend[0].resp; end
      if (bv_on) bresp_i = b_pend[0];
      #1;
      full  = (exp_q.size() >= 4);
      e_ar  = cke & cur_req & ~cur_we & ~full;
      e_aw  = cke & cur_req & cur_we & ~full & ~aw_seen;
      e_w   = cke & cur_req & cur_we & ~full & ~w_seen;
      e_gnt = cur_we ? (cke & cur_req & ~full & (aw_seen | (e_aw & awready)) & (w_seen | (e_w & wready)))
                     : (e_ar & arready);
      e_rr  = cke & (exp_q.size() > 0) && !exp_q[0].wr;
      e_br  = cke & (exp_q.size() > 0) && exp_q[0].wr;
      rf = rvalid_i & e_rr;
      bf = bvalid_i & e_br;
      chk("rnd_araddr", araddr, obi_addr & 32'hFFFF_FFFC);
      chk("rnd_arvalid", arvalid, e_ar);
      chk("rnd_awvalid", awvalid, e_aw);
      chk("rnd_wvalid", wvalid, e_w);
      chk("rnd_gnt", gnt, e_gnt);
      chk("rnd_rready", rready, e_rr);
      chk("rnd_bready", bready, e_br);
      chk("rnd_rvalid", obi_rvalid, rf | bf);
      if (rf | bf) begin
        chk("rnd_rdata", obi_rdata, exp_q[0].data);
        chk("rnd_err", obi_err, exp_q[0].err);
        void'(exp_q.pop_front());
      end
      if (rf) begin void'(r_pend.pop_front()); rv_on = 0; end
      if (bf) begin void'(b_pend.pop_front()); bv_on = 0; end
      if (e_aw & awready) aw_seen = 1;
      if (e_w & wready) w_seen = 1;
      if (e_gnt) begin
        if (cur_we) begin
          br = 2'($urandom);
          b_pend.push_back(br);
          ex.wr = 1; ex.data = 0; ex.err = br[1];
        end else begin
          rs.data = $urandom; rs.resp = 2'($urandom);
          r_pend.push_back(rs);
          ex.wr = 0; ex.data = rs.data; ex.err = rs.resp[1];
        end
        exp_q.push_back(ex);
        cur_req = 0; aw_seen = 0; w_seen = 0;
      end
    end
    @(negedge clk); idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
